and4_qual_filter: RTL and testbench
===================================

AND4_QUAL_FILTER -- requirements
Module: and4_qual_filter

Interface
REQ-001 Parameter FILT_LEN, default 3: consecutive cycles the registered 4-input AND must be true before Q asserts; legal range 1..15.
REQ-002 CLK  input  1  clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 IN1, IN2, IN3, IN4  input  1 each  raw condition inputs, asynchronous to nothing, sampled on CLK.
REQ-005 CLR  input  1  synchronous clear of the event counter.
REQ-006 Q  output  1  qualified AND result, registered.
REQ-007 QN  output  1  complement of Q, registered.
REQ-008 RISE  output  1  one-cycle pulse, high in the first cycle Q is high.
REQ-009 CNT  output  8  qualified-event count.
REQ-010 SAT  output  1  high when CNT equals 255.

Function
REQ-011 Each edge SHALL capture IN1..IN4 into a 4-bit sample register S; A = AND of the four S bits.
REQ-012 The FSM SHALL have three states: IDLE, QUAL, ACTIVE; 4-bit run counter RUN.
REQ-013 IDLE: A=1 and FILT_LEN=1 -> ACTIVE; A=1 and FILT_LEN>1 -> QUAL with RUN=1; A=0 -> stay, RUN=0.
REQ-014 QUAL: A=0 -> IDLE, RUN=0; A=1 and RUN=FILT_LEN-1 -> ACTIVE; otherwise RUN increments.
REQ-015 ACTIVE: A=0 -> IDLE, RUN=0; A=1 -> stay.
REQ-016 Q SHALL be 1 exactly when state is ACTIVE; QN = not Q at all times, including reset.
REQ-017 Rise latency: all inputs high from the edge that captures S=1111 (edge 0) -> Q=1 after edge FILT_LEN.
REQ-018 Fall latency: any input low captured at edge m -> Q=0 after edge m+1; no filtering on deassertion.
REQ-019 An A=0 sample in QUAL SHALL abort qualification; restart requires FILT_LEN fresh consecutive A=1 samples.
REQ-020 RISE SHALL be 1 for exactly the single cycle after the IDLE/QUAL->ACTIVE transition edge.
REQ-021 CNT SHALL increment by 1 on each edge where RISE is being set, saturating at 255 (no wrap).
REQ-022 CLR=1 SHALL set CNT=0 at the edge; CLR takes priority over a simultaneous increment (that event is lost).
REQ-023 SAT SHALL be combinationally CNT==255.

Reset
REQ-024 RST=1 at an edge SHALL force S=0000, state IDLE, RUN=0, Q=0, QN=1, RISE=0, CNT=0.
REQ-025 RST SHALL override CLR and all inputs; asserting RST mid-QUAL or in ACTIVE aborts immediately; qualification restarts from IDLE after RST releases.

Configuration
REQ-026 Macro AND4_QUAL_FILTER_CNT_EN defined: CNT, SAT and CLR logic SHALL be implemented per REQ-021..023.
REQ-027 Macro undefined: CNT SHALL be tied to 0, SAT to 0, CLR ignored; port list unchanged; Q/QN/RISE behaviour identical.

Verification
REQ-028 FILT_LEN=3, RST 2 cycles, then IN=1111 held -> Q=0 after edges 0..2, Q=1 and RISE=1 after edge 3, RISE=0 after edge 4, CNT=1.
REQ-029 FILT_LEN=3, IN=1111 for 2 samples, IN3=0 for 1 sample, then 1111 held -> Q rises only 3 edges after the return to 1111; CNT=1.
REQ-030 Q=1, drop IN4 for one sample -> Q=0 one edge later, QN=1; restore -> Q re-asserts after 3 more edges, CNT increments to 2.
REQ-031 Generate 256 qualified events -> CNT=255, SAT=1, stays 255 after 257th; then CLR=1 coincident with a RISE edge -> CNT=0.
REQ-032 RST asserted while state is QUAL with RUN=2 -> all outputs at reset values next edge; after release with 1111 held, Q needs full FILT_LEN again.
REQ-033 Rerun REQ-028 and REQ-031 with AND4_QUAL_FILTER_CNT_EN undefined -> Q/RISE timing identical, CNT=0 and SAT=0 throughout.

Source files
------------

// File: rtl/and4_qual_filter_if.sv
// Signal bundle for and4_qual_filter: the raw AND inputs, the counter clear,
// and the qualified outputs. The master drives the inputs; the slave is the filter.
interface and4_qual_filter_if;
    logic       IN1;
    logic       IN2;
    logic       IN3;
    logic       IN4;
    logic       CLR;
    logic       Q;
    logic       QN;
    logic       RISE;
    logic [7:0] CNT;
    logic       SAT;

    modport master (
        output IN1, IN2, IN3, IN4, CLR,
        input  Q, QN, RISE, CNT, SAT
    );

    modport slave (
        input  IN1, IN2, IN3, IN4, CLR,
        output Q, QN, RISE, CNT, SAT
    );
endinterface

// File: rtl/and4_qual_filter.sv
// and4_qual_filter: registered 4-input AND that must hold true for FILT_LEN
// consecutive samples before Q asserts; deassertion is unfiltered.
// RISE pulses for the first ACTIVE cycle. The saturating event counter
// (CNT/SAT/CLR) exists only when AND4_QUAL_FILTER_CNT_EN is defined;
// otherwise CNT and SAT read 0 and CLR is ignored.
module and4_qual_filter #(
    parameter int FILT_LEN = 3
) (
    input logic               CLK,
    input logic               RST,
    and4_qual_filter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        QUAL,
        ACTIVE
    } state_t;

    localparam logic [3:0] RUN_LAST = 4'(FILT_LEN - 1);

    logic [3:0] s;
    logic       a;
    state_t     state;
    state_t     next_state;
    logic [3:0] run;
    logic [3:0] next_run;
    logic       q;
    logic       qn;
    logic       rise;
    logic       rise_set;

    // Capture the raw inputs every edge; the AND is taken on the sampled copy.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s <= '0;
        end else begin
            s <= {bus.IN1, bus.IN2, bus.IN3, bus.IN4};
        end
    end

    assign a = &s;

    // Qualification decision: count consecutive A=1 samples, drop out on any A=0.
    always_comb begin
        next_state = state;
        next_run   = run;
        case (state)
            IDLE: begin
                if (a) begin
                    if (FILT_LEN == 1) begin
                        next_state = ACTIVE;
                        next_run   = '0;
                    end else begin
                        next_state = QUAL;
                        next_run   = 4'd1;
                    end
                end else begin
                    next_run = '0;
                end
            end
            QUAL: begin
                if (!a) begin
                    next_state = IDLE;
                    next_run   = '0;
                end else if (run == RUN_LAST) begin
                    next_state = ACTIVE;
                    next_run   = '0;
                end else begin
                    next_run = run + 4'd1;
                end
            end
            ACTIVE: begin
                if (!a) begin
                    next_state = IDLE;
                    next_run   = '0;
                end
            end
            default: begin
                next_state = IDLE;
                next_run   = '0;
            end
        endcase
    end

    assign rise_set = (next_state == ACTIVE) && (state != ACTIVE);

    // State, run counter and the registered Q/QN/RISE outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            run   <= '0;
            q     <= 1'b0;
            qn    <= 1'b1;
            rise  <= 1'b0;
        end else begin
            state <= next_state;
            run   <= next_run;
            q     <= (next_state == ACTIVE);
            qn    <= (next_state != ACTIVE);
            rise  <= rise_set;
        end
    end

    assign bus.Q    = q;
    assign bus.QN   = qn;
    assign bus.RISE = rise;

`ifdef AND4_QUAL_FILTER_CNT_EN
    logic [7:0] cnt;

    // Saturating event counter; a clear wins over a coincident increment.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (bus.CLR) begin
            cnt <= '0;
        end else if (rise_set && (cnt != 8'hFF)) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign bus.CNT = cnt;
    assign bus.SAT = (cnt == 8'hFF);
`else
    assign bus.CNT = '0;
    assign bus.SAT = 1'b0;
`endif

endmodule

// File: tb/tb_and4_qual_filter.sv
// Directed bench for and4_qual_filter with FILT_LEN=3. Inputs change 1 ns
// after a rising edge and outputs are checked 1 ns after the next one.
// Counter expectations follow AND4_QUAL_FILTER_CNT_EN.
module tb_and4_qual_filter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   events   = 0;

    and4_qual_filter_if bus ();

    and4_qual_filter #(.FILT_LEN(3)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_cnt(input int n);
`ifdef AND4_QUAL_FILTER_CNT_EN
        return (n > 255) ? 8'hFF : 8'(n);
`else
        return 8'h00;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] v);
        bus.IN1 = v[3];
        bus.IN2 = v[2];
        bus.IN3 = v[1];
        bus.IN4 = v[0];
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic q_e, input logic rise_e);
        logic [7:0] c;
        c = exp_cnt(events);
        check({tag, ".Q"}, {7'd0, bus.Q}, {7'd0, q_e});
        check({tag, ".QN"}, {7'd0, bus.QN}, {7'd0, ~q_e});
        check({tag, ".RISE"}, {7'd0, bus.RISE}, {7'd0, rise_e});
        check({tag, ".CNT"}, bus.CNT, c);
        check({tag, ".SAT"}, {7'd0, bus.SAT}, {7'd0, (c == 8'hFF)});
    endtask

    // From ACTIVE: drop to IDLE, then qualify again; optional CLR on the rising edge.
    task automatic qual_event(input string tag, input logic clr_on_rise);
        set_in(4'b0000);
        step();
        step();
        check_outs({tag, ".idle"}, 1'b0, 1'b0);
        set_in(4'b1111);
        step();
        step();
        step();
        check_outs({tag, ".qual"}, 1'b0, 1'b0);
        if (clr_on_rise) bus.CLR = 1'b1;
        step();
        bus.CLR = 1'b0;
        if (clr_on_rise) events = 0;
        else events++;
        check_outs({tag, ".rise"}, 1'b1, 1'b1);
    endtask

    initial begin
        set_in(4'b0000);
        bus.CLR = 1'b0;

        // Reset state
        rst = 1'b1;
        step();
        step();
        check_outs("reset", 1'b0, 1'b0);

        // Basic qualification: 1111 held from edge 0
        rst = 1'b0;
        set_in(4'b1111);
        step();
        check_outs("basic.e0", 1'b0, 1'b0);
        step();
        check_outs("basic.e1", 1'b0, 1'b0);
        step();
        check_outs("basic.e2", 1'b0, 1'b0);
        step();
        events = 1;
        check_outs("basic.e3", 1'b1, 1'b1);
        step();
        check_outs("basic.e4", 1'b1, 1'b0);

        // Single-sample dropout on IN4 while active; no filtering on fall
        set_in(4'b1110);
        step();
        check_outs("drop.m", 1'b1, 1'b0);
        set_in(4'b1111);
        step();
        check_outs("drop.m1", 1'b0, 1'b0);
        step();
        check_outs("drop.r1", 1'b0, 1'b0);
        step();
        check_outs("drop.r2", 1'b0, 1'b0);
        step();
        events = 2;
        check_outs("drop.r3", 1'b1, 1'b1);

        // Abort mid-qualification: two 1111 samples, one with IN3 low
        set_in(4'b0000);
        step();
        step();
        check_outs("abort.idle", 1'b0, 1'b0);
        set_in(4'b1111);
        step();
        step();
        set_in(4'b1101);
        step();
        check_outs("abort.e2", 1'b0, 1'b0);
        set_in(4'b1111);
        step();
        check_outs("abort.e3", 1'b0, 1'b0);
        step();
        check_outs("abort.e4", 1'b0, 1'b0);
        step();
        check_outs("abort.e5", 1'b0, 1'b0);
        step();
        events = 3;
        check_outs("abort.e6", 1'b1, 1'b1);

        // Reset while qualifying with RUN=2, with CLR also asserted
        set_in(4'b0000);
        step();
        step();
        set_in(4'b1111);
        step();
        step();
        step();
        rst = 1'b1;
        bus.CLR = 1'b1;
        step();
        events = 0;
        check_outs("rstq.hit", 1'b0, 1'b0);
        rst = 1'b0;
        bus.CLR = 1'b0;
        step();
        check_outs("rstq.e0", 1'b0, 1'b0);
        step();
        check_outs("rstq.e1", 1'b0, 1'b0);
        step();
        check_outs("rstq.e2", 1'b0, 1'b0);
        step();
        events = 1;
        check_outs("rstq.e3", 1'b1, 1'b1);

        // Saturation: drive the count to 256 events, then one more
        for (int i = 0; i < 256; i++) begin
            qual_event("sat", 1'b0);
        end
        check({"sat.final", ".CNT"}, bus.CNT, exp_cnt(257));

        // CLR coincident with a rising edge: count cleared, event lost
        qual_event("clr", 1'b1);
        qual_event("post", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
